// File: rtl/victim_pkg.sv
// Shared dcache / victim-cache parameters, tag-field positions and the swap FSM state type.
package victim_pkg;

  localparam int DCACHE_LINE_WIDTH = 128;
  localparam int DCACHE_TAG_BITS   = 20;
  localparam int VICTIM_NO_OF_SETS = 4;
  localparam int VICTIM_IDX_BITS   = $clog2(VICTIM_NO_OF_SETS);
  localparam int TAG_VALID_BIT     = 19;
  localparam int TAG_DIRTY_BIT     = 18;

  typedef logic [DCACHE_LINE_WIDTH-1:0] line_t;
  typedef logic [DCACHE_TAG_BITS-1:0]   tag_t;

  typedef enum logic [2:0] {
    IDLE,
    PROBE,
    MEM_WB,
    MEM_RD,
    VWRITE,
    FILL
  } swap_state_e;

  // The victim only ever holds clean lines, and a forced valid bit keeps all-zero entries from matching.
  function automatic tag_t clean_valid_tag(input tag_t tag);
    tag_t result;
    result                = tag;
    result[TAG_VALID_BIT] = 1'b1;
    result[TAG_DIRTY_BIT] = 1'b0;
    return result;
  endfunction

endpackage

// File: rtl/victim_cache.sv
// Small fully-associative victim cache: FIFO replacement, combinational lookup,
// lowest-index entry wins when duplicates exist.
module victim_cache
  import victim_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DCACHE_TAG_BITS-1:0]   cache_to_victim_tag,
  input  logic [DCACHE_LINE_WIDTH-1:0] cache_to_victim_data,
  input  logic                         write_to_victim,
  output logic [DCACHE_LINE_WIDTH-1:0] victim_to_cache_data,
  output logic                         victim_hit
);

  tag_t                     tag_q  [VICTIM_NO_OF_SETS];
  tag_t                     tag_d  [VICTIM_NO_OF_SETS];
  line_t                    data_q [VICTIM_NO_OF_SETS];
  line_t                    data_d [VICTIM_NO_OF_SETS];
  logic [VICTIM_IDX_BITS-1:0] wr_ptr_q, wr_ptr_d;

  // Scanning from the top down lets the lowest matching index overwrite the result last.
  always_comb begin
    victim_hit           = 1'b0;
    victim_to_cache_data = '0;
    for (int i = VICTIM_NO_OF_SETS - 1; i >= 0; i--) begin
      if (tag_q[i] == cache_to_victim_tag) begin
        victim_hit           = 1'b1;
        victim_to_cache_data = data_q[i];
      end
    end
  end

  always_comb begin
    tag_d    = tag_q;
    data_d   = data_q;
    wr_ptr_d = wr_ptr_q;
    if (write_to_victim) begin
      tag_d[wr_ptr_q]  = cache_to_victim_tag;
      data_d[wr_ptr_q] = cache_to_victim_data;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < VICTIM_NO_OF_SETS; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
      wr_ptr_q <= '0;
    end else begin
      tag_q    <= tag_d;
      data_q   <= data_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

endmodule

// File: rtl/victim_swap_ctrl.sv
// Dcache miss handler: probes the victim cache, writes back dirty victims, reads memory
// on a victim miss, pushes the evicted line into the victim cache and returns the fill.
module victim_swap_ctrl
  import victim_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         miss_req,
  output logic                         miss_ready,
  input  logic [DCACHE_TAG_BITS-1:0]   miss_tag,
  input  logic                         evict_valid,
  input  logic                         evict_dirty,
  input  logic [DCACHE_TAG_BITS-1:0]   evict_tag,
  input  logic [DCACHE_LINE_WIDTH-1:0] evict_data,
  output logic                         fill_valid,
  output logic [DCACHE_LINE_WIDTH-1:0] fill_data,
  output logic [DCACHE_TAG_BITS-1:0]   fill_tag,
  output logic                         fill_from_victim,
  output logic [DCACHE_TAG_BITS-1:0]   victim_tag,
  output logic [DCACHE_LINE_WIDTH-1:0] victim_wdata,
  output logic                         victim_write,
  input  logic [DCACHE_LINE_WIDTH-1:0] victim_rdata,
  input  logic                         victim_hit,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [DCACHE_TAG_BITS-1:0]   mem_tag,
  output logic [DCACHE_LINE_WIDTH-1:0] mem_wdata,
  input  logic                         mem_ack,
  input  logic [DCACHE_LINE_WIDTH-1:0] mem_rdata
);

  swap_state_e state_q, state_d;

  tag_t  miss_tag_q, miss_tag_d;
  logic  ev_valid_q, ev_valid_d;
  logic  ev_dirty_q, ev_dirty_d;
  tag_t  ev_tag_q, ev_tag_d;
  line_t ev_data_q, ev_data_d;
  line_t line_q, line_d;
  logic  src_q, src_d;

  logic  miss_ready_q, miss_ready_d;
  logic  fill_valid_q, fill_valid_d;
  line_t fill_data_q, fill_data_d;
  tag_t  fill_tag_q, fill_tag_d;
  logic  fill_from_victim_q, fill_from_victim_d;
  tag_t  victim_tag_q, victim_tag_d;
  line_t victim_wdata_q, victim_wdata_d;
  logic  victim_write_q, victim_write_d;
  logic  mem_req_q, mem_req_d;
  logic  mem_we_q, mem_we_d;
  tag_t  mem_tag_q, mem_tag_d;
  line_t mem_wdata_q, mem_wdata_d;

  // Next-state and capture logic; outputs below are then derived from the state being entered
  // so every interface signal comes straight from a flop.
  always_comb begin
    state_d    = state_q;
    miss_tag_d = miss_tag_q;
    ev_valid_d = ev_valid_q;
    ev_dirty_d = ev_dirty_q;
    ev_tag_d   = ev_tag_q;
    ev_data_d  = ev_data_q;
    line_d     = line_q;
    src_d      = src_q;

    case (state_q)
      IDLE: begin
        if (miss_req) begin
          miss_tag_d = clean_valid_tag(miss_tag);
          ev_valid_d = evict_valid;
          ev_dirty_d = evict_dirty;
          ev_tag_d   = evict_tag;
          ev_data_d  = evict_data;
          src_d      = 1'b0;
          state_d    = PROBE;
        end
      end
      PROBE: begin
        if (victim_hit) begin
          line_d = victim_rdata;
          src_d  = 1'b1;
        end
        if (ev_valid_q && ev_dirty_q)  state_d = MEM_WB;
        else if (!victim_hit)          state_d = MEM_RD;
        else if (ev_valid_q)           state_d = VWRITE;
        else                           state_d = FILL;
      end
      MEM_WB: begin
        if (mem_ack) state_d = src_q ? VWRITE : MEM_RD;
      end
      MEM_RD: begin
        if (mem_ack) begin
          line_d  = mem_rdata;
          state_d = ev_valid_q ? VWRITE : FILL;
        end
      end
      VWRITE:  state_d = FILL;
      FILL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    miss_ready_d       = (state_d == IDLE);
    fill_valid_d       = 1'b0;
    fill_data_d        = fill_data_q;
    fill_tag_d         = fill_tag_q;
    fill_from_victim_d = fill_from_victim_q;
    victim_tag_d       = victim_tag_q;
    victim_wdata_d     = victim_wdata_q;
    victim_write_d     = 1'b0;
    mem_req_d          = 1'b0;
    mem_we_d           = 1'b0;
    mem_tag_d          = mem_tag_q;
    mem_wdata_d        = mem_wdata_q;

    case (state_d)
      PROBE: victim_tag_d = miss_tag_d;
      MEM_WB: begin
        mem_req_d   = 1'b1;
        mem_we_d    = 1'b1;
        mem_tag_d   = ev_tag_d;
        mem_wdata_d = ev_data_d;
      end
      MEM_RD: begin
        mem_req_d = 1'b1;
        mem_tag_d = miss_tag_d;
      end
      VWRITE: begin
        victim_write_d = 1'b1;
        victim_tag_d   = clean_valid_tag(ev_tag_d);
        victim_wdata_d = ev_data_d;
      end
      FILL: begin
        fill_valid_d       = 1'b1;
        fill_data_d        = line_d;
        fill_tag_d         = miss_tag_d;
        fill_from_victim_d = src_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q            <= IDLE;
      miss_tag_q         <= '0;
      ev_valid_q         <= 1'b0;
      ev_dirty_q         <= 1'b0;
      ev_tag_q           <= '0;
      ev_data_q          <= '0;
      line_q             <= '0;
      src_q              <= 1'b0;
      miss_ready_q       <= 1'b1;
      fill_valid_q       <= 1'b0;
      fill_data_q        <= '0;
      fill_tag_q         <= '0;
      fill_from_victim_q <= 1'b0;
      victim_tag_q       <= '0;
      victim_wdata_q     <= '0;
      victim_write_q     <= 1'b0;
      mem_req_q          <= 1'b0;
      mem_we_q           <= 1'b0;
      mem_tag_q          <= '0;
      mem_wdata_q        <= '0;
    end else begin
      state_q            <= state_d;
      miss_tag_q         <= miss_tag_d;
      ev_valid_q         <= ev_valid_d;
      ev_dirty_q         <= ev_dirty_d;
      ev_tag_q           <= ev_tag_d;
      ev_data_q          <= ev_data_d;
      line_q             <= line_d;
      src_q              <= src_d;
      miss_ready_q       <= miss_ready_d;
      fill_valid_q       <= fill_valid_d;
      fill_data_q        <= fill_data_d;
      fill_tag_q         <= fill_tag_d;
      fill_from_victim_q <= fill_from_victim_d;
      victim_tag_q       <= victim_tag_d;
      victim_wdata_q     <= victim_wdata_d;
      victim_write_q     <= victim_write_d;
      mem_req_q          <= mem_req_d;
      mem_we_q           <= mem_we_d;
      mem_tag_q          <= mem_tag_d;
      mem_wdata_q        <= mem_wdata_d;
    end
  end

  assign miss_ready       = miss_ready_q;
  assign fill_valid       = fill_valid_q;
  assign fill_data        = fill_data_q;
  assign fill_tag         = fill_tag_q;
  assign fill_from_victim = fill_from_victim_q;
  assign victim_tag       = victim_tag_q;
  assign victim_wdata     = victim_wdata_q;
  assign victim_write     = victim_write_q;
  assign mem_req          = mem_req_q;
  assign mem_we           = mem_we_q;
  assign mem_tag          = mem_tag_q;
  assign mem_wdata        = mem_wdata_q;

endmodule

// File: tb/tb_victim_swap_ctrl.sv
// Bench for victim_swap_ctrl wired to the real victim_cache; directed scenarios followed by
// random misses, all checked against a transaction-level model of the victim store and memory.
module tb_victim_swap_ctrl;
  import victim_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         miss_req;
  logic         miss_ready;
  logic [19:0]  miss_tag;
  logic         evict_valid;
  logic         evict_dirty;
  logic [19:0]  evict_tag;
  logic [127:0] evict_data;
  logic         fill_valid;
  logic [127:0] fill_data;
  logic [19:0]  fill_tag;
  logic         fill_from_victim;
  logic [19:0]  victim_tag;
  logic [127:0] victim_wdata;
  logic         victim_write;
  logic [127:0] victim_rdata;
  logic         victim_hit;
  logic         mem_req;
  logic         mem_we;
  logic [19:0]  mem_tag;
  logic [127:0] mem_wdata;
  logic         mem_ack;
  logic [127:0] mem_rdata;

  always #5 clk = ~clk;

  victim_swap_ctrl dut (
    .clk(clk), .rst(rst),
    .miss_req(miss_req), .miss_ready(miss_ready), .miss_tag(miss_tag),
    .evict_valid(evict_valid), .evict_dirty(evict_dirty),
    .evict_tag(evict_tag), .evict_data(evict_data),
    .fill_valid(fill_valid), .fill_data(fill_data), .fill_tag(fill_tag),
    .fill_from_victim(fill_from_victim),
    .victim_tag(victim_tag), .victim_wdata(victim_wdata), .victim_write(victim_write),
    .victim_rdata(victim_rdata), .victim_hit(victim_hit),
    .mem_req(mem_req), .mem_we(mem_we), .mem_tag(mem_tag), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  victim_cache u_victim (
    .clk(clk), .rst(rst),
    .cache_to_victim_tag(victim_tag), .cache_to_victim_data(victim_wdata),
    .write_to_victim(victim_write),
    .victim_to_cache_data(victim_rdata), .victim_hit(victim_hit)
  );

  int assert_count = 0;
  int fail_count   = 0;

  logic [19:0]  model_tag  [4];
  logic [127:0] model_data [4];
  int           model_ptr;

  logic [127:0] last_fill_data;
  logic [19:0]  last_fill_tag;
  logic         last_src;
  int           last_latency;
  int           last_wb_cnt, last_rd_cnt, last_vw_cnt;
  logic [19:0]  last_wb_tag, last_rd_tag, last_vw_tag;
  logic [127:0] last_vw_data;

  function automatic logic [19:0] clean_valid(input logic [19:0] t);
    return (t | 20'h80000) & 20'hBFFFF;
  endfunction

  function automatic logic [127:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] observed,
                             input logic [127:0] expected);
    assert_count++;
    assert (observed === expected)
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", name, observed, expected);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      model_tag[i]  = '0;
      model_data[i] = '0;
    end
    model_ptr = 0;
  endtask

  // One transaction from the accept cycle until the cycle after fill, with a memory responder.
  task automatic runTxn(input logic [19:0] m_tag, input logic ev_v, input logic ev_d,
                        input logic [19:0] ev_tag, input logic [127:0] ev_data,
                        input int delay, input logic [127:0] rd_data, input bit hold);
    logic         exp_hit, exp_wb, exp_rd, exp_vw;
    logic [127:0] hit_data, exp_fill;
    int           exp_lat;
    logic         done, busy_ready, unstable, overlap, pend, pend_we;
    logic [19:0]  pend_tag, wb_tag, rd_tag, vw_tag;
    logic [127:0] wb_data, vw_data, f_data;
    logic [19:0]  f_tag;
    logic         f_src;
    int           wait_cnt, wb_cnt, rd_cnt, vw_cnt, wb_k, rd_k, lat;

    exp_hit  = 1'b0;
    hit_data = '0;
    for (int i = 0; i < 4; i++) begin
      if (!exp_hit && model_tag[i] == clean_valid(m_tag)) begin
        exp_hit  = 1'b1;
        hit_data = model_data[i];
      end
    end
    exp_wb   = ev_v && ev_d;
    exp_rd   = !exp_hit;
    exp_vw   = ev_v;
    exp_fill = exp_hit ? hit_data : rd_data;
    exp_lat  = 2 + (exp_wb ? delay + 1 : 0) + (exp_rd ? delay + 1 : 0) + (exp_vw ? 1 : 0);

    done = 0; busy_ready = 0; unstable = 0; overlap = 0; pend = 0; pend_we = 0;
    pend_tag = '0; wb_tag = '0; rd_tag = '0; vw_tag = '0;
    wb_data = '0; vw_data = '0; f_data = '0; f_tag = '0; f_src = 0;
    wait_cnt = 0; wb_cnt = 0; rd_cnt = 0; vw_cnt = 0; wb_k = 0; rd_k = 0; lat = 0;

    for (int k = 1; k <= 80 && !done; k++) begin
      @(negedge clk);
      if (k == 1 && !hold) miss_req = 1'b0;
      if (miss_ready) busy_ready = 1;
      if (mem_req) begin
        if (pend && (mem_tag != pend_tag || mem_we != pend_we)) unstable = 1;
        if (wait_cnt == delay) begin
          mem_ack = 1'b1;
          if (mem_we) begin
            wb_cnt++; wb_tag = mem_tag; wb_data = mem_wdata; wb_k = k;
            mem_rdata = rand_line();
          end else begin
            rd_cnt++; rd_tag = mem_tag; rd_k = k;
            mem_rdata = rd_data;
          end
          wait_cnt = 0;
          pend     = 0;
        end else begin
          mem_ack  = 1'b0;
          wait_cnt++;
          pend     = 1;
          pend_tag = mem_tag;
          pend_we  = mem_we;
        end
      end else begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
        pend     = 0;
      end
      if (victim_write) begin
        vw_cnt++; vw_tag = victim_tag; vw_data = victim_wdata;
        if (mem_req) overlap = 1;
      end
      if (fill_valid) begin
        done = 1; lat = k; f_data = fill_data; f_tag = fill_tag; f_src = fill_from_victim;
      end
    end
    mem_ack = 1'b0;
    if (!done) begin
      miss_req = 1'b0;
      checkOutput("fill_timeout", 128'(done), 128'(1));
    end

    checkOutput("latency", 128'(lat), 128'(exp_lat));
    checkOutput("fill_data", f_data, exp_fill);
    checkOutput("fill_tag", 128'(f_tag), 128'(clean_valid(m_tag)));
    checkOutput("fill_src", 128'(f_src), 128'(exp_hit));
    checkOutput("wb_count", 128'(wb_cnt), 128'(exp_wb ? 1 : 0));
    checkOutput("rd_count", 128'(rd_cnt), 128'(exp_rd ? 1 : 0));
    checkOutput("vw_count", 128'(vw_cnt), 128'(exp_vw ? 1 : 0));
    if (exp_wb) begin
      checkOutput("wb_tag", 128'(wb_tag), 128'(ev_tag));
      checkOutput("wb_data", wb_data, ev_data);
    end
    if (exp_rd) checkOutput("rd_tag", 128'(rd_tag), 128'(clean_valid(m_tag)));
    if (exp_wb && exp_rd) checkOutput("wb_before_rd", 128'(wb_k < rd_k), 128'(1));
    if (exp_vw) begin
      checkOutput("vw_tag", 128'(vw_tag), 128'(clean_valid(ev_tag)));
      checkOutput("vw_data", vw_data, ev_data);
    end
    checkOutput("busy_not_ready", 128'(busy_ready), 128'(0));
    checkOutput("req_stable", 128'(unstable), 128'(0));
    checkOutput("vw_mem_overlap", 128'(overlap), 128'(0));

    last_fill_data = f_data; last_fill_tag = f_tag; last_src = f_src; last_latency = lat;
    last_wb_cnt = wb_cnt; last_rd_cnt = rd_cnt; last_vw_cnt = vw_cnt;
    last_wb_tag = wb_tag; last_rd_tag = rd_tag; last_vw_tag = vw_tag; last_vw_data = vw_data;

    if (exp_vw) begin
      model_tag[model_ptr]  = clean_valid(ev_tag);
      model_data[model_ptr] = ev_data;
      model_ptr             = (model_ptr + 1) % 4;
    end

    @(negedge clk);
    checkOutput("fill_pulse", 128'(fill_valid), 128'(0));
    checkOutput("ready_after_fill", 128'(miss_ready), 128'(1));
  endtask

  // Presents a miss at a negedge while IDLE; with hold the request stays up for a second accept.
  task automatic applyStimulus(input logic [19:0] m_tag, input logic ev_v, input logic ev_d,
                               input logic [19:0] ev_tag, input logic [127:0] ev_data,
                               input int delay, input logic [127:0] rd_data, input bit hold);
    int w;
    w = 0;
    while (!miss_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!miss_ready) checkOutput("ready_timeout", 128'(miss_ready), 128'(1));
    miss_tag    = m_tag;
    evict_valid = ev_v;
    evict_dirty = ev_d;
    evict_tag   = ev_tag;
    evict_data  = ev_data;
    miss_req    = 1'b1;
    runTxn(m_tag, ev_v, ev_d, ev_tag, ev_data, delay, rd_data, hold);
    if (hold) runTxn(m_tag, ev_v, ev_d, ev_tag, ev_data, delay, rd_data, 1'b0);
  endtask

  initial begin
    logic [127:0] d1, d2, d3, a5, rd;
    logic         saw_rd, saw_fill;
    logic [19:0]  r_tag, r_ev_tag;
    logic         r_v, r_d;
    int           r_delay;
    bit           r_hold;

    rst = 1'b0; miss_req = 1'b0; miss_tag = '0; evict_valid = 1'b0; evict_dirty = 1'b0;
    evict_tag = '0; evict_data = '0; mem_ack = 1'b0; mem_rdata = '0;
    model_reset();
    d1 = 128'h11111111_22222222_33333333_44444444;
    d2 = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
    d3 = 128'h0F0F0F0F_F0F0F0F0_5A5A5A5A_A5A5A5A5;
    a5 = {16{8'hA5}};

    repeat (2) @(negedge clk);
    checkOutput("rst_miss_ready", 128'(miss_ready), 128'(1));
    checkOutput("rst_fill_valid", 128'(fill_valid), 128'(0));
    checkOutput("rst_mem_req", 128'(mem_req), 128'(0));
    checkOutput("rst_mem_we", 128'(mem_we), 128'(0));
    checkOutput("rst_victim_write", 128'(victim_write), 128'(0));
    checkOutput("rst_fill_src", 128'(fill_from_victim), 128'(0));
    checkOutput("rst_fill_data", fill_data, 128'(0));
    checkOutput("rst_mem_tag", 128'(mem_tag), 128'(0));
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] cold miss");
    applyStimulus(20'h80123, 1'b0, 1'b0, 20'h0, '0, 2, a5, 1'b0);
    checkOutput("cold_rd_tag", 128'(last_rd_tag), 128'(20'h80123));
    checkOutput("cold_no_vw", 128'(last_vw_cnt), 128'(0));
    checkOutput("cold_fill_data", last_fill_data, a5);
    checkOutput("cold_src", 128'(last_src), 128'(0));

    $display("[TB] victim hit swap");
    applyStimulus(20'h80020, 1'b1, 1'b0, 20'h00010, d1, 1, rand_line(), 1'b0);
    checkOutput("swap1_vw_tag", 128'(last_vw_tag), 128'(20'h80010));
    applyStimulus(20'h80010, 1'b1, 1'b0, 20'h80020, d2, 1, rand_line(), 1'b0);
    checkOutput("swap2_src", 128'(last_src), 128'(1));
    checkOutput("swap2_fill_data", last_fill_data, d1);
    checkOutput("swap2_no_mem", 128'(last_rd_cnt + last_wb_cnt), 128'(0));
    checkOutput("swap2_vw_tag", 128'(last_vw_tag), 128'(20'h80020));
    checkOutput("swap2_vw_data", last_vw_data, d2);
    checkOutput("swap2_latency", 128'(last_latency), 128'(3));

    $display("[TB] dirty evict");
    applyStimulus(20'h80040, 1'b1, 1'b1, 20'hC0030, d3, 1, rand_line(), 1'b0);
    checkOutput("dirty_wb_tag", 128'(last_wb_tag), 128'(20'hC0030));
    checkOutput("dirty_rd_tag", 128'(last_rd_tag), 128'(20'h80040));
    checkOutput("dirty_vw_tag", 128'(last_vw_tag), 128'(20'h80030));

    $display("[TB] zero-wait ack and held request");
    applyStimulus(20'h80777, 1'b0, 1'b0, 20'h0, '0, 0, rand_line(), 1'b0);
    checkOutput("zero_wait_latency", 128'(last_latency), 128'(3));
    applyStimulus(20'h80778, 1'b0, 1'b0, 20'h0, '0, 0, rand_line(), 1'b1);

    $display("[TB] reset during MEM_RD");
    miss_tag = 20'h8BEEF; evict_valid = 1'b0; evict_dirty = 1'b0; miss_req = 1'b1;
    @(negedge clk);
    miss_req = 1'b0;
    saw_rd = 1'b0;
    for (int k = 0; k < 10 && !saw_rd; k++) begin
      @(negedge clk);
      if (mem_req && !mem_we) saw_rd = 1'b1;
    end
    checkOutput("rst_test_reached_rd", 128'(saw_rd), 128'(1));
    #2 rst = 1'b0;
    #1;
    checkOutput("async_mem_req_drop", 128'(mem_req), 128'(0));
    checkOutput("async_miss_ready", 128'(miss_ready), 128'(1));
    checkOutput("async_victim_write", 128'(victim_write), 128'(0));
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    saw_fill = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (fill_valid || mem_req) saw_fill = 1'b1;
    end
    checkOutput("no_fill_after_reset", 128'(saw_fill), 128'(0));

    $display("[TB] wrap-around");
    for (int i = 1; i <= 5; i++)
      applyStimulus(20'h80200 + 20'(i), 1'b1, 1'b0, 20'h80000 + 20'(i), rand_line(), 1,
                    rand_line(), 1'b0);
    applyStimulus(20'h80001, 1'b0, 1'b0, 20'h0, '0, 1, rand_line(), 1'b0);
    checkOutput("wrap_slot0_gone", 128'(last_rd_cnt), 128'(1));
    checkOutput("wrap_slot0_src", 128'(last_src), 128'(0));
    applyStimulus(20'h80005, 1'b0, 1'b0, 20'h0, '0, 1, rand_line(), 1'b0);
    checkOutput("wrap_newest_hit", 128'(last_src), 128'(1));

    $display("[TB] random misses");
    for (int n = 0; n < 40; n++) begin
      r_tag    = 20'h80000 | 20'($urandom_range(0, 7));
      r_ev_tag = 20'($urandom_range(0, 7)) | (20'($urandom_range(0, 3)) << 18);
      r_v      = 1'($urandom_range(0, 1));
      r_d      = 1'($urandom_range(0, 1));
      r_delay  = int'($urandom_range(0, 3));
      r_hold   = ($urandom_range(0, 7) == 0);
      rd       = rand_line();
      applyStimulus(r_tag, r_v, r_d, r_ev_tag, rand_line(), r_delay, rd, r_hold);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
